// File: rtl/arm_mem_pkg.sv
// ---------------------------------------------------------------------------
// arm_mem_pkg
// Shared definitions for the MEM-stage SRAM controller: SRAM bus widths,
// default timing/address-map constants and the access FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package arm_mem_pkg;

    localparam int SRAM_DW             = 16;
    localparam int SRAM_AW             = 18;
    // One 32-bit word spans two half-words, so the word address is one bit narrower
    localparam int WADDR_W             = SRAM_AW - 1;
    localparam int DEFAULT_ADDR_BASE   = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_WAIT,
        ST_DONE
    } mem_state_e;

endpackage

// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
// Memory-side responder of the pipeline ready/stall handshake. Converts one
// 32-bit load/store from the MEM stage into two 16-bit SRAM accesses (low
// half-word first) and holds o_ready low for exactly WAIT_CYCLES cycles,
// then raises it for a single cycle when the access completes.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   i_wr_en, i_rd_en   store / load request, held while o_ready = 0
//   i_address          byte address; i_write_data store data
//   o_read_data        load data, valid from the DONE cycle onward
//   o_ready            0 = stall pipeline, 1 = idle or access done
//   o_sram_addr        SRAM half-word address
//   o_sram_dq_out/oe   write data and pad output enable
//   i_sram_dq_in       data read from the pad
//   o_sram_we_n        SRAM write enable (active low)
//   o_sram_ub_n/lb_n/ce_n/oe_n  permanently enabled (tied low)
// ---------------------------------------------------------------------------
module sram_mem_controller
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int ADDR_BASE   = DEFAULT_ADDR_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_en,
    input  logic               i_rd_en,
    input  logic [31:0]        i_address,
    input  logic [31:0]        i_write_data,
    output logic [31:0]        o_read_data,
    output logic               o_ready,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [SRAM_DW-1:0] o_sram_dq_out,
    output logic               o_sram_dq_oe,
    input  logic [SRAM_DW-1:0] i_sram_dq_in,
    output logic               o_sram_we_n,
    output logic               o_sram_ub_n,
    output logic               o_sram_lb_n,
    output logic               o_sram_ce_n,
    output logic               o_sram_oe_n
);

    // Counter only has to hold WAIT_CYCLES-3; keep at least one bit when no WAIT state exists
    localparam int              WCW       = (WAIT_CYCLES > 3) ? $clog2(WAIT_CYCLES - 2) : 1;
    localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(WAIT_CYCLES - 3);

    mem_state_e           r_state;
    mem_state_e           w_next_state;
    logic                 w_req;
    logic [31:0]          w_offset;
    logic [WADDR_W-1:0]   w_waddr;
    logic                 w_unused_offset_bits;

    logic [WADDR_W-1:0]   r_waddr;
    logic [SRAM_DW-1:0]   r_wdata_hi;
    logic                 r_is_write;
    logic [SRAM_DW-1:0]   r_rd_lo;
    logic [31:0]          r_read_data;
    logic [WCW-1:0]       r_wait;
    logic [SRAM_AW-1:0]   r_sram_addr;
    logic [SRAM_DW-1:0]   r_sram_dq_out;
    logic                 r_sram_dq_oe;
    logic                 r_sram_we_n;

    assign w_req    = i_wr_en | i_rd_en;
    // Address wraps silently inside the 17-bit word space; no range check
    assign w_offset = i_address - 32'(ADDR_BASE);
    assign w_waddr  = w_offset[WADDR_W+1:2];
    assign w_unused_offset_bits = &{1'b0, w_offset[31:WADDR_W+2], w_offset[1:0]};

    assign o_read_data   = r_read_data;
    assign o_sram_addr   = r_sram_addr;
    assign o_sram_dq_out = r_sram_dq_out;
    assign o_sram_dq_oe  = r_sram_dq_oe;
    assign o_sram_we_n   = r_sram_we_n;
    assign o_sram_ub_n   = 1'b0;
    assign o_sram_lb_n   = 1'b0;
    assign o_sram_ce_n   = 1'b0;
    assign o_sram_oe_n   = 1'b0;

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and ready. In IDLE ready follows the request combinationally
    // so the requesting instruction is stalled in its very first cycle.
    always_comb begin
        w_next_state = r_state;
        o_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = ~w_req;
                if (w_req) w_next_state = ST_LOW;
            end
            ST_LOW:  w_next_state = ST_HIGH;
            ST_HIGH: w_next_state = (WAIT_LOAD == '0) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (r_wait <= WCW'(1)) w_next_state = ST_DONE;
            ST_DONE: begin
                o_ready      = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath. SRAM strobes are registered and set up on the edge that
    // enters LOW/HIGH, so they are stable for the whole half-word cycle;
    // read data is sampled on the edge that leaves that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waddr       <= '0;
            r_wdata_hi    <= '0;
            r_is_write    <= 1'b0;
            r_rd_lo       <= '0;
            r_read_data   <= '0;
            r_wait        <= '0;
            r_sram_addr   <= '0;
            r_sram_dq_out <= '0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_we_n   <= 1'b1;
        end else begin
            r_sram_we_n  <= 1'b1;
            r_sram_dq_oe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_waddr     <= w_waddr;
                        r_wdata_hi  <= i_write_data[31:16];
                        r_is_write  <= i_wr_en;
                        r_sram_addr <= {w_waddr, 1'b0};
                        if (i_wr_en) begin
                            r_sram_we_n   <= 1'b0;
                            r_sram_dq_oe  <= 1'b1;
                            r_sram_dq_out <= i_write_data[15:0];
                        end
                    end
                end
                ST_LOW: begin
                    if (!r_is_write) r_rd_lo <= i_sram_dq_in;
                    r_sram_addr <= {r_waddr, 1'b1};
                    if (r_is_write) begin
                        r_sram_we_n   <= 1'b0;
                        r_sram_dq_oe  <= 1'b1;
                        r_sram_dq_out <= r_wdata_hi;
                    end
                end
                ST_HIGH: begin
                    // Both halves land together so read_data never shows a torn word
                    if (!r_is_write) r_read_data <= {i_sram_dq_in, r_rd_lo};
                    r_wait <= WAIT_LOAD;
                end
                ST_WAIT: r_wait <= r_wait - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
